// File: rtl/serial_addsub_core_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
// Optional zero flag is enabled by defining SERIAL_ADDSUB_ZERO_FLAG_EN.
package addsub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of a counter able to index every bit of a w-bit operand.
  function automatic int cnt_width(input int w);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << r) < w) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_addsub_core_if.sv
// Operand/result bundle between the operand inverter side and the serial engine.
// Carries the zero flag only when SERIAL_ADDSUB_ZERO_FLAG_EN is defined.
interface serial_addsub_core_if
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  // Handshake: start is accepted on a rising edge only while busy=0 (IDLE or
  // the DONE cycle); a, invb and d are captured on that edge and may change
  // afterwards. done is a one-cycle pulse marking sum/cout/ovf as freshly valid.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] invb;
  logic             d;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  logic             zero;

  modport master (output start, a, invb, d,
                  input  busy, done, sum, cout, ovf, zero);
  modport slave  (input  start, a, invb, d,
                  output busy, done, sum, cout, ovf, zero);
`else
  modport master (output start, a, invb, d,
                  input  busy, done, sum, cout, ovf);
  modport slave  (input  start, a, invb, d,
                  output busy, done, sum, cout, ovf);
`endif

endinterface

// File: rtl/serial_addsub_core_full_adder_bit.sv
// One-bit combinational full adder used for each serial step.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_addsub_core.sv
// Bit-serial add/subtract engine: one bit per clock, LSB first, d is carry-in.
// Define SERIAL_ADDSUB_ZERO_FLAG_EN to add the result-is-zero flag.
module serial_addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_addsub_core_if.slave   bus,
  output state_t                dbg_state
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] r_sr;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;
  logic             load, step, last_step;
  logic             busy_c, done_c;
  logic             fa_s, fa_c;

  full_adder_bit u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy_c = 1'b1;
        step   = 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        done_c = 1'b1;
        // A start seen in the DONE cycle chains straight into the next operation.
        if (bus.start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign last_step = step && (cnt_q == LAST);

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  logic zero_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      r_sr    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else if (load) begin
      a_sr    <= bus.a;
      b_sr    <= bus.invb;
      carry_q <= bus.d;
      cnt_q   <= '0;
    end else if (step) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      carry_q <= fa_c;
      r_sr    <= (WIDTH-1)'({fa_s, r_sr} >> 1);
      cnt_q   <= cnt_q + CNT_W'(1);
      // On the MSB step carry_q is the carry into the MSB, giving signed overflow.
      if (last_step) begin
        sum_q  <= {fa_s, r_sr};
        cout_q <= fa_c;
        ovf_q  <= carry_q ^ fa_c;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        zero_q <= ({fa_s, r_sr} == '0);
`endif
      end
    end
  end

  assign bus.busy  = busy_c;
  assign bus.done  = done_c;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  assign bus.zero  = zero_q;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_addsub_core.sv
// Directed bench for serial_addsub_core with hand-computed expected results.
// Zero-flag checks are compiled in when SERIAL_ADDSUB_ZERO_FLAG_EN is defined.
module tb_serial_addsub_core;
  import addsub_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     n_vec;
  int     n_err;
  logic [3:0] prev_sum;
  int     bc;
  bit     got;

  serial_addsub_core_if #(.WIDTH(4)) bus ();

  serial_addsub_core #(.WIDTH(4), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [3:0] ta, input logic [3:0] tb_, input logic td);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.invb  = tb_;
    bus.d     = td;
  endtask

  // Waits (bounded) for done at negedges, counting busy cycles; scrambles inputs
  // after the accepting edge and optionally pokes start while the engine is busy.
  task automatic wait_done(input bit poke, input logic [3:0] hold,
                           output int bcnt, output bit seen);
    bcnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = 4'($urandom_range(0, 15));
      bus.invb  = 4'($urandom_range(0, 15));
      bus.d     = 1'($urandom_range(0, 1));
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) bcnt++;
      if (i == 1) chk("sum_hold", bus.sum, hold);
      if (poke && i >= 1 && i <= 3) bus.start = 1'b1;
    end
  endtask

  task automatic check_result(input string tag, input logic [3:0] es,
                              input logic ec, input logic eo);
    chk({tag, "_done"}, got, 1);
    chk({tag, "_busy_cycles"}, bc, 4);
    chk({tag, "_sum"}, bus.sum, es);
    chk({tag, "_cout"}, bus.cout, ec);
    chk({tag, "_ovf"}, bus.ovf, eo);
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    chk({tag, "_zero"}, bus.zero, (es == 4'd0));
`endif
    prev_sum = es;
  endtask

  task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_,
                        input logic td, input logic [3:0] es, input logic ec,
                        input logic eo, input bit poke, input bit b2b);
    launch(ta, tb_, td);
    wait_done(poke, prev_sum, bc, got);
    check_result(tag, es, ec, eo);
    if (!b2b) begin
      @(negedge clk);
      chk({tag, "_done_pulse"}, bus.done, 0);
      chk({tag, "_idle"}, dbg_state, IDLE);
      chk({tag, "_sum_held"}, bus.sum, es);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    prev_sum  = 4'd0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 4'd0;
    bus.invb  = 4'd0;
    bus.d     = 1'b0;

    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_state", dbg_state, IDLE);
    @(negedge clk);
    rst = 1'b0;

    run_op("sub_5_3",  4'd5,    4'b1100, 1'b1, 4'd2,    1'b1, 1'b0, 1'b0, 1'b0);
    run_op("add_7_1",  4'd7,    4'd1,    1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("sub_m8_1", 4'b1000, 4'b1110, 1'b1, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("sub_3_3",  4'd3,    4'b1100, 1'b1, 4'd0,    1'b1, 1'b0, 1'b0, 1'b0);
    run_op("busy_poke", 4'd6,   4'd1,    1'b0, 4'd7,    1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back: start held through the DONE cycle chains 2+2 with no IDLE gap.
    run_op("b2b_first", 4'd3,   4'd2,    1'b0, 4'd5,    1'b0, 1'b0, 1'b0, 1'b1);
    bus.start = 1'b1;
    bus.a     = 4'd2;
    bus.invb  = 4'd2;
    bus.d     = 1'b0;
    wait_done(1'b0, prev_sum, bc, got);
    check_result("b2b_second", 4'd4, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_done_pulse", bus.done, 0);

    // Reset in the middle of an operation after a completed result of 9.
    run_op("nine", 4'd4, 4'd5, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    launch(4'd1, 4'd2, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("mid_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_sum", bus.sum, 0);
    chk("arst_cout", bus.cout, 0);
    chk("arst_ovf", bus.ovf, 0);
    chk("arst_state", dbg_state, IDLE);
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    chk("arst_zero", bus.zero, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", bus.done, 0);
    end
    chk("post_rst_sum", bus.sum, 0);
    prev_sum = 4'd0;
    run_op("post_rst_1_1", 4'd1, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
